// File: rtl/toy_mem_initiator.sv
// toy_mem_initiator: single-outstanding req/ack memory initiator between a core-side client and a memory adapter.
// Optional ack watchdog enabled by defining TOY_MEM_INIT_TIMEOUT_EN.
module toy_mem_initiator #(
  parameter logic [3:0] SRC_ID      = 4'd1,
  parameter logic [3:0] TGT_ID      = 4'd0,
  parameter int         TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd_strb,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        req_vld,
  input  logic        req_rdy,
  output logic [31:0] req_addr,
  output logic [31:0] req_data,
  output logic [3:0]  req_strb,
  output logic        req_opcode,
  output logic [3:0]  req_src_id,
  output logic [3:0]  req_tgt_id,
  input  logic        ack_vld,
  output logic        ack_rdy,
  input  logic        ack_opcode,
  input  logic [31:0] ack_data,
  input  logic [3:0]  ack_src_id,
  input  logic [3:0]  ack_tgt_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;
  state_t      state;
  logic        opcode;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  strb;
  logic        match, expire, unused;
  assign cmd_rdy    = state == IDLE;
  assign req_vld    = state == REQ;
  assign rsp_vld    = state == RSP;
  assign ack_rdy    = state != RSP;
  assign busy       = state != IDLE;
  assign req_addr   = addr;
  assign req_data   = wdata;
  assign req_strb   = strb;
  assign req_opcode = opcode;
  assign req_src_id = SRC_ID;
  assign req_tgt_id = TGT_ID;
  assign rsp_data   = rdata;
  assign unused     = ^ack_src_id;
  // Anything accepted outside WAIT or not addressed to this request is a stale ack and is simply consumed.
  assign match = ack_vld && ack_rdy && state == WAIT && ack_tgt_id == SRC_ID && ack_opcode == opcode;
`ifdef TOY_MEM_INIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          err;
  assign expire  = state == WAIT && !match && cnt == CW'(TIMEOUT_CYC - 1);
  assign rsp_err = err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      err <= state == WAIT ? expire : state == RSP && !rsp_rdy && err;
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opcode <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      strb   <= '0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_vld) begin
          state  <= REQ;
          opcode <= cmd_wr;
          addr   <= cmd_addr;
          wdata  <= cmd_wdata;
          strb   <= cmd_wr ? cmd_strb : 4'b0000;
        end
        REQ: if (req_rdy) state <= WAIT;
        WAIT: if (match || expire) begin
          state <= RSP;
          rdata <= match && !opcode ? ack_data : '0;
        end
        RSP: if (rsp_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_toy_mem_initiator.sv
// tb_toy_mem_initiator: directed bench with a transaction-level reference model checked every cycle.
module tb_toy_mem_initiator;
  localparam logic [3:0] SRC = 4'd1;
  localparam logic [3:0] TGT = 4'd0;
  localparam int         TO  = 8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld = 1'b0, cmd_rdy, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_vld, rsp_rdy = 1'b1, rsp_err;
  logic [31:0] rsp_data;
  logic        req_vld, req_rdy = 1'b1, req_opcode;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strb, req_src_id, req_tgt_id;
  logic        ack_vld = 1'b0, ack_rdy, ack_opcode = 1'b0;
  logic [31:0] ack_data = '0;
  logic [3:0]  ack_src_id = TGT, ack_tgt_id = SRC;
  logic        busy;
  int n_chk = 0, n_fail = 0;
  bit started = 0;

  toy_mem_initiator #(.SRC_ID(SRC), .TGT_ID(TGT), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr),
    .cmd_wr(cmd_wr), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata), .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err), .req_vld(req_vld),
    .req_rdy(req_rdy), .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .req_opcode(req_opcode), .req_src_id(req_src_id), .req_tgt_id(req_tgt_id),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_opcode(ack_opcode), .ack_data(ack_data),
    .ack_src_id(ack_src_id), .ack_tgt_id(ack_tgt_id), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction view: phase 0 free, 1 request offered, 2 awaiting ack, 3 response offered.
  int          ph = 0, waited = 0;
  logic        m_wr = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0;
  logic [3:0]  m_strb = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; m_err = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_wr = 0;
    end else if (ph == 0) begin
      if (cmd_vld) begin
        ph = 1; m_addr = cmd_addr; m_wdata = cmd_wdata; m_wr = cmd_wr; m_strb = cmd_wr ? cmd_strb : 4'h0;
      end
    end else if (ph == 1) begin
      if (req_rdy) begin ph = 2; waited = 0; end
    end else if (ph == 2) begin
      if (ack_vld && ack_tgt_id == SRC && ack_opcode == m_wr) begin
        ph = 3; m_err = 0; m_data = m_wr ? 32'h0 : ack_data;
      end else begin
        waited++;
`ifdef TOY_MEM_INIT_TIMEOUT_EN
        if (waited == TO) begin ph = 3; m_err = 1; m_data = 0; end
`endif
      end
    end else if (rsp_rdy) begin
      ph = 0; m_err = 0;
    end
  end

  always @(negedge clk) if (started) begin
    chk("cmd_rdy", 32'(cmd_rdy), 32'(ph == 0));
    chk("req_vld", 32'(req_vld), 32'(ph == 1));
    chk("rsp_vld", 32'(rsp_vld), 32'(ph == 3));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("ack_rdy", 32'(ack_rdy), 32'(ph != 3));
    chk("ids", {24'h0, req_src_id, req_tgt_id}, {24'h0, SRC, TGT});
    chk("rsp_err", 32'(rsp_err), 32'(ph == 3 && m_err));
    if (ph == 1) begin
      chk("req_addr", req_addr, m_addr);
      chk("req_data", req_data, m_wdata);
      chk("req_strb", 32'(req_strb), 32'(m_strb));
      chk("req_opcode", 32'(req_opcode), 32'(m_wr));
    end
    if (ph == 3) chk("rsp_data", rsp_data, m_data);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    int k = 0;
    cmd_vld = 1; cmd_addr = a; cmd_wr = w; cmd_strb = s; cmd_wdata = d;
    while (!cmd_rdy && k < 50) begin step(); k++; end
    if (!cmd_rdy) chk("cmd_accept_timeout", 32'(cmd_rdy), 32'd1);
    step();
    cmd_vld = 0;
    chk("req_vld_latency", 32'(req_vld), 32'd1);
  endtask

  task automatic do_ack(input logic [3:0] tgt, input logic op, input logic [31:0] d);
    ack_vld = 1; ack_tgt_id = tgt; ack_opcode = op; ack_data = d;
    step();
    ack_vld = 0;
  endtask

  initial begin
    rst_n = 1;
    #1 rst_n = 0;
    step();
    started = 1;
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    step();
    rst_n = 1;
    step();
    // Read
    send_cmd(32'h100, 0, 4'hF, 32'hAAAA5555);
    chk("rd_req_addr", req_addr, 32'h100);
    chk("rd_req_strb", 32'(req_strb), 32'h0);
    chk("rd_req_op", 32'(req_opcode), 32'h0);
    step();
    do_ack(SRC, 0, 32'hDEADBEEF);
    chk("rd_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("rd_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    step();
    chk("rd_idle", 32'(cmd_rdy), 32'd1);
    // Write
    send_cmd(32'h4, 1, 4'b0011, 32'h12345678);
    chk("wr_req_addr", req_addr, 32'h4);
    chk("wr_req_data", req_data, 32'h12345678);
    chk("wr_req_strb", 32'(req_strb), 32'h3);
    chk("wr_req_op", 32'(req_opcode), 32'h1);
    step();
    do_ack(SRC, 1, 32'hFFFFFFFF);
    chk("wr_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("wr_rsp_data", rsp_data, 32'h0);
    step();
    // Backpressure on req, then on rsp
    req_rdy = 0;
    send_cmd(32'h200, 1, 4'hF, 32'hCAFEF00D);
    cmd_vld = 1; cmd_addr = 32'h999; cmd_wr = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_addr", req_addr, 32'h200);
      chk("bp_req_data", req_data, 32'hCAFEF00D);
      chk("bp_cmd_rdy", 32'(cmd_rdy), 32'd0);
      step();
    end
    cmd_vld = 0;
    req_rdy = 1;
    step();
    rsp_rdy = 0;
    do_ack(SRC, 1, 32'h0);
    ack_vld = 1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_held", 32'(rsp_vld), 32'd1);
      chk("bp_ack_rdy", 32'(ack_rdy), 32'd0);
      step();
    end
    ack_vld = 0;
    rsp_rdy = 1;
    step();
    chk("bp_done", 32'(cmd_rdy), 32'd1);
    // Stale acks
    do_ack(SRC, 0, 32'h1111);
    chk("stale_idle", 32'(cmd_rdy), 32'd1);
    send_cmd(32'h300, 0, 4'h0, 32'h0);
    step();
    do_ack(SRC + 4'd1, 0, 32'h2222);
    chk("stale_tgt", 32'(rsp_vld), 32'd0);
    do_ack(SRC, 1, 32'h2323);
    chk("stale_op", 32'(rsp_vld), 32'd0);
    chk("stale_busy", 32'(busy), 32'd1);
    do_ack(SRC, 0, 32'h3333);
    chk("good_rsp", rsp_data, 32'h3333);
    step();
    chk("single_rsp", 32'(rsp_vld), 32'd0);
    // Watchdog
    send_cmd(32'h400, 0, 4'h0, 32'h0);
    step();
`ifdef TOY_MEM_INIT_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      chk("to_wait", 32'(rsp_vld), 32'd0);
      step();
    end
    chk("to_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", rsp_data, 32'h0);
    step();
    do_ack(SRC, 0, 32'h5555);
    chk("to_late_ack", 32'(rsp_vld), 32'd0);
    send_cmd(32'h404, 0, 4'h0, 32'h0);
    step();
`else
    for (int i = 0; i < 20; i++) begin
      chk("no_to_wait", 32'(rsp_vld), 32'd0);
      step();
    end
`endif
    do_ack(SRC, 0, 32'h600D);
    chk("after_wait_data", rsp_data, 32'h600D);
    chk("after_wait_err", 32'(rsp_err), 32'd0);
    step();
    // Reset during WAIT
    send_cmd(32'h500, 0, 4'h0, 32'h0);
    step();
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("mid_rst_req_addr", req_addr, 32'h0);
    chk("mid_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    step();
    rst_n = 1;
    do_ack(SRC, 0, 32'h7777);
    chk("post_rst_ack", 32'(busy), 32'd0);
    send_cmd(32'h600, 0, 4'h0, 32'h0);
    step();
    do_ack(SRC, 0, 32'h8888);
    chk("post_rst_rsp", rsp_data, 32'h8888);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
